mul_share_arbiter: RTL and testbench

- Shares one 16x16 signed combinational multiplier between two requesters.
- Each requester has its own operand channel and result channel, both valid/ready.
- Round-robin arbitration, registered operands and registered product, so the multiplier sits between two flop stages.
- One operation in flight at a time. Sits between the processing lanes and the multiplier datapath.

---
 rtl/mul_share_arbiter_pkg.sv | 12 +
 rtl/mul_share_arbiter_if.sv | 23 ++
 rtl/mul_share_arbiter_datapath.sv | 27 ++
 rtl/mul_share_arbiter.sv | 88 ++++++++
 tb/tb_mul_share_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_share_arbiter_pkg.sv
// rtl/mul_share_arbiter_pkg.sv - shared types and widths for the shared-multiplier arbiter
package mul_share_pkg;

  localparam int W    = 16;
  localparam int NREQ = 2;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  typedef logic signed [W-1:0]   operand_t;
  typedef logic signed [2*W-1:0] product_t;

endpackage

// File: rtl/mul_share_arbiter_if.sv
// rtl/mul_share_arbiter_if.sv - operand and result channels of both requesters
interface mul_share_arbiter_if;
  import mul_share_pkg::*;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  product_t          rsp_product;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_product
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_product
  );

endinterface

// File: rtl/mul_share_arbiter_datapath.sv
// rtl/mul_share_arbiter_datapath.sv - combinational W x W signed shift-and-add multiplier
module mul_datapath
  import mul_share_pkg::*;
(
  input  operand_t a_i,
  input  operand_t b_i,
  output product_t p_o
);

  localparam logic [2*W-1:0] LSB_ONE = 1;

  logic [2*W-1:0] a_ext;
  logic [2*W-1:0] acc;

  assign a_ext = {{W{a_i[W-1]}}, a_i};

  // The top bit of b carries weight -2^(W-1), so its row is subtracted.
  always_comb begin
    acc = '0;
    for (int i = 0; i < W-1; i++) begin
      if (b_i[i]) acc = acc + (a_ext << i);
    end
    if (b_i[W-1]) acc = acc + ~(a_ext << (W-1)) + LSB_ONE;
    p_o = acc;
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin sharing of one signed multiplier between two requesters
module mul_share_arbiter
  import mul_share_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  mul_share_arbiter_if.slave  bus,
  output logic                busy
);

  state_t   state_q, state_d;
  logic     rr_ptr_q, rr_ptr_d;
  logic     id_q, id_d;
  operand_t a_q, a_d, b_q, b_d;
  product_t product_q, product_d, mul_p;

  logic any_valid;
  logic grant;

  assign any_valid = |bus.req_valid;
  assign grant     = (&bus.req_valid) ? rr_ptr_q : bus.req_valid[1];

  mul_datapath u_mul (
    .a_i (a_q),
    .b_i (b_q),
    .p_o (mul_p)
  );

  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE && any_valid && !rst) bus.req_ready[grant] = 1'b1;
    bus.rsp_valid = '0;
    if (state_q == RESP && !rst) bus.rsp_valid[id_q] = 1'b1;
  end

  assign bus.rsp_product = product_q;
  assign busy            = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          id_d    = grant;
          a_d     = grant ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0];
          b_d     = grant ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0];
          state_d = CALC;
        end
      end
      CALC: begin
        product_d = mul_p;
        state_d   = RESP;
      end
      RESP: begin
        // Hand the next tie to the requester that was not just served.
        if (bus.rsp_ready[id_q]) begin
          rr_ptr_d = ~id_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= 1'b0;
      id_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      id_q      <= id_d;
      a_q       <= a_d;
      b_q       <= b_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - self-checking bench for mul_share_arbiter
module tb_mul_share_arbiter;
  import mul_share_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  mul_share_arbiter_if bus();

  mul_share_arbiter dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          req;
    int          a;
    int          b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(logic signed [15:0] a, logic signed [15:0] b);
    int p;
    p = int'(a) * int'(b);
    return p;
  endfunction

  task automatic set_req(int i, logic v, int a, int b);
    bus.req_valid[i]        = v;
    bus.req_a[i*16 +: 16]   = a[15:0];
    bus.req_b[i*16 +: 16]   = b[15:0];
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    #1;
    check("reset outputs", {31'd0, busy} | {28'd0, bus.req_ready, bus.rsp_valid}, 32'd0);
    check("reset product", bus.rsp_product, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_op(int i, int a, int b, logic [31:0] exp, string tag);
    int w;
    w = 0;
    @(negedge clk);
    set_req(i, 1'b1, a, b);
    bus.rsp_ready = '1;
    #1;
    while (!bus.req_ready[i] && w < 10) begin
      @(negedge clk);
      #1;
      w++;
    end
    check({tag, " accept wait"}, w, 0);
    @(negedge clk);
    set_req(i, 1'b0, 0, 0);
    #1;
    check({tag, " calc"}, {29'd0, busy, bus.rsp_valid}, 32'b100);
    @(negedge clk);
    #1;
    check({tag, " rsp_valid"}, {30'd0, bus.rsp_valid}, (i == 0) ? 32'd1 : 32'd2);
    check({tag, " product"}, bus.rsp_product, exp);
    @(negedge clk);
    #1;
    check({tag, " back idle"}, {29'd0, busy, bus.rsp_valid}, 32'd0);
  endtask

  function automatic logic [15:0] rand16();
    case ($urandom_range(0, 11))
      0: return 16'h8000;
      1: return 16'h7fff;
      2: return 16'h0000;
      3: return 16'hffff;
      4: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  // Transaction-level reference for the random phase.
  logic [31:0]       expq[2][$];
  logic signed [15:0] cur_a[2];
  logic signed [15:0] cur_b[2];

  initial begin
    int gcount;
    int last_acc[2];
    int cyc;
    int issued;
    int done_ops;
    int inflight;
    int fl_id;
    int fl_cyc;
    int last_served;
    logic [1:0] acc;
    logic [1:0] prev_wait;
    logic [1:0] exp_ready;
    logic [1:0] exp_rv;
    logic [31:0] pexp[2];

    vecs[0] = '{0,     -3,      7, 32'hFFFF_FFEB};
    vecs[1] = '{0,    100,    200, 32'h0000_4E20};
    vecs[2] = '{1,     -1,  32767, 32'hFFFF_8001};
    vecs[3] = '{1, -32768, -32768, 32'h4000_0000};
    vecs[4] = '{1, -32768,      1, 32'hFFFF_8000};
    vecs[5] = '{1,      0,     -5, 32'h0000_0000};

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = '0;
    #1;
    check("por busy", {31'd0, busy}, 32'd0);
    check("por valids", {28'd0, bus.req_ready, bus.rsp_valid}, 32'd0);
    check("por product", bus.rsp_product, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 6; k++)
      do_op(vecs[k].req, vecs[k].a, vecs[k].b, vecs[k].exp, $sformatf("vec%0d", k));

    // Both requesters held valid: strict alternation, one service each per 6 cycles.
    reset_pulse();
    @(negedge clk);
    set_req(0, 1'b1, 100, 200);
    set_req(1, 1'b1, -1, 32767);
    bus.rsp_ready = 2'b11;
    pexp[0] = 32'h0000_4E20;
    pexp[1] = 32'hFFFF_8001;
    last_acc[0] = -1;
    last_acc[1] = -1;
    gcount = 0;
    for (int c = 0; c < 25; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (bus.req_ready[i]) begin
          check("alt grant order", i, gcount % 2);
          if (last_acc[i] >= 0) check("alt period", c - last_acc[i], 6);
          last_acc[i] = c;
          gcount++;
        end
        if (bus.rsp_valid[i]) check("alt product", bus.rsp_product, pexp[i]);
      end
    end
    check("alt grant count", gcount, 9);

    // Response back-pressure on requester 0 while requester 1 waits.
    reset_pulse();
    @(negedge clk);
    set_req(0, 1'b1, 5, 6);
    bus.rsp_ready = 2'b00;
    #1;
    check("bp accept0", {30'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    set_req(0, 1'b0, 0, 0);
    set_req(1, 1'b1, 7, 8);
    #1;
    check("bp calc ready", {30'd0, bus.req_ready}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.rsp_ready = 2'b10;
      #1;
      check("bp hold valid", {30'd0, bus.rsp_valid}, 32'd1);
      check("bp hold product", bus.rsp_product, 32'd30);
      check("bp hold ready", {30'd0, bus.req_ready}, 32'd0);
    end
    @(negedge clk);
    bus.rsp_ready = 2'b01;
    #1;
    check("bp release ready", {30'd0, bus.req_ready}, 32'd0);
    check("bp release valid", {30'd0, bus.rsp_valid}, 32'd1);
    @(negedge clk);
    #1;
    check("bp grant1", {30'd0, bus.req_ready}, 32'd2);
    @(negedge clk);
    set_req(1, 1'b0, 0, 0);
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    #1;
    check("bp rsp1 valid", {30'd0, bus.rsp_valid}, 32'd2);
    check("bp rsp1 product", bus.rsp_product, 32'd56);

    // Reset while CALC: abort and restore tie preference to requester 0.
    reset_pulse();
    do_op(0, 2, 3, 32'd6, "pre-abort");
    @(negedge clk);
    set_req(0, 1'b1, 9, 9);
    #1;
    check("abort accept", {30'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    set_req(0, 1'b0, 0, 0);
    #1;
    check("abort in calc", {31'd0, busy}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("abort outputs", {27'd0, busy, bus.req_ready, bus.rsp_valid}, 32'd0);
    check("abort product", bus.rsp_product, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("abort no rsp", {29'd0, busy, bus.rsp_valid}, 32'd0);
    end
    @(negedge clk);
    set_req(0, 1'b1, 1, 1);
    set_req(1, 1'b1, 1, 1);
    #1;
    check("abort tie to 0", {30'd0, bus.req_ready}, 32'd1);

    // Random traffic against the transaction-level model.
    reset_pulse();
    issued = 0;
    done_ops = 0;
    inflight = 0;
    fl_id = 0;
    fl_cyc = 0;
    last_served = -1;
    acc = '0;
    prev_wait = '0;
    cyc = 0;
    while (done_ops < 2000 && cyc < 40000) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) bus.req_valid[i] = 1'b0;
        if (!bus.req_valid[i] && issued < 2000 && $urandom_range(0, 2) == 0) begin
          cur_a[i] = rand16();
          cur_b[i] = rand16();
          set_req(i, 1'b1, int'(cur_a[i]), int'(cur_b[i]));
          issued++;
        end
        bus.rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int i = 0; i < 2; i++)
        if (prev_wait[i]) check("rand valid held", {31'd0, bus.req_valid[i]}, 32'd1);

      exp_ready = '0;
      if (inflight == 0 && bus.req_valid != 2'b00) begin
        if (bus.req_valid == 2'b11) exp_ready = (last_served == 0) ? 2'b10 : 2'b01;
        else                         exp_ready = bus.req_valid;
      end
      check("rand req_ready", {30'd0, bus.req_ready}, {30'd0, exp_ready});

      exp_rv = '0;
      if (inflight != 0 && cyc >= fl_cyc + 2) exp_rv = (fl_id == 0) ? 2'b01 : 2'b10;
      check("rand rsp_valid", {30'd0, bus.rsp_valid}, {30'd0, exp_rv});

      if (exp_rv != 2'b00 && bus.rsp_ready[fl_id]) begin
        if (expq[fl_id].size() == 0) begin
          check("rand dup response", 32'd1, 32'd0);
        end else begin
          check("rand product", bus.rsp_product, expq[fl_id].pop_front());
        end
        done_ops++;
        last_served = fl_id;
        inflight = 0;
      end

      acc = bus.req_valid & bus.req_ready;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          expq[i].push_back(ref_mul(cur_a[i], cur_b[i]));
          inflight = 1;
          fl_id = i;
          fl_cyc = cyc;
        end
      end
      prev_wait = bus.req_valid & ~bus.req_ready;
      cyc++;
    end
    check("rand ops completed", done_ops, 2000);
    check("rand none lost", expq[0].size() + expq[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
